// File: rtl/cmp_pkg.sv
// cmp_pkg: shared constants for the bit-serial magnitude comparator.
//   IDLE/RUN                 - FSM state encodings
//   RES_EQ/RES_GT/RES_LT     - internal result encodings
//   res_to_flags()           - result -> {gt, eq, lt} one-hot flags
//   CMP_WIDTH_DEF            - default operand width
package cmp_pkg;

  localparam int unsigned CMP_WIDTH_DEF = 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] RES_EQ = 2'd0;
  localparam logic [1:0] RES_GT = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

  function automatic logic [2:0] res_to_flags(input logic [1:0] res);
    logic [2:0] flags;
    case (res)
      RES_GT:  flags = 3'b100;
      RES_LT:  flags = 3'b001;
      default: flags = 3'b010;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/cmp_bit_step.sv
// cmp_bit_step: one MSB-first comparison step (combinational).
//   a_bit, b_bit  - current operand bits
//   is_sign_bit   - this is the first (sign) bit examined
//   signed_mode   - operands are two's-complement
//   decided       - a difference was already found
//   prev_result   - result so far (RES_* encoding)
//   decided_next, result_next - updated decision state
module cmp_bit_step
  import cmp_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic       is_sign_bit,
  input  logic       signed_mode,
  input  logic       decided,
  input  logic [1:0] prev_result,
  output logic       decided_next,
  output logic [1:0] result_next
);

  always_comb begin
    decided_next = decided;
    result_next  = prev_result;
    if (!decided && (a_bit != b_bit)) begin
      decided_next = 1'b1;
      // A set sign bit means a negative value, so the sense flips there.
      if (a_bit ^ (is_sign_bit & signed_mode)) begin
        result_next = RES_GT;
      end else begin
        result_next = RES_LT;
      end
    end
  end

endmodule

// File: rtl/serial_mag_compare.sv
// serial_mag_compare: bit-serial MSB-first magnitude comparator.
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - request a compare (accepted when ready=1)
//   a_in, b_in    - operands, sampled on the accepting edge
//   ready         - idle, able to accept start
//   done          - one-cycle pulse, gt/eq/lt valid
//   gt, eq, lt    - registered one-hot result, held until next completion
// Parameters: WIDTH (>=1), SIGNED (1 = two's-complement operands).
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to finish on the first
// differing bit instead of always taking WIDTH edges.
module serial_mag_compare
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = CMP_WIDTH_DEF,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_decided;
  logic [1:0]       r_result;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic             w_is_sign;
  logic             w_last;
  logic             w_finish;
  logic             w_decided_next;
  logic [1:0]       w_result_next;
  logic [2:0]       w_flags;

  // Counter still holds WIDTH-1 only on the first RUN edge (the sign bit).
  assign w_is_sign = (r_cnt == CNT_LAST);
  assign w_last    = (r_cnt == '0);

  cmp_bit_step u_step (
    .a_bit        (r_a[WIDTH-1]),
    .b_bit        (r_b[WIDTH-1]),
    .is_sign_bit  (w_is_sign),
    .signed_mode  (SIGNED),
    .decided      (r_decided),
    .prev_result  (r_result),
    .decided_next (w_decided_next),
    .result_next  (w_result_next)
  );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign w_finish = w_last | w_decided_next;
`else
  assign w_finish = w_last;
`endif

  assign w_flags = res_to_flags(w_result_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_result  <= RES_EQ;
      r_done    <= 1'b0;
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a       <= a_in;
            r_b       <= b_in;
            r_cnt     <= CNT_LAST;
            r_decided <= 1'b0;
            r_result  <= RES_EQ;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_a       <= r_a << 1;
          r_b       <= r_b << 1;
          r_cnt     <= r_cnt - CW'(1);
          r_decided <= w_decided_next;
          r_result  <= w_result_next;
          if (w_finish) begin
            {r_gt, r_eq, r_lt} <= w_flags;
            r_done             <= 1'b1;
            r_state            <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready = (r_state == IDLE);
  assign done  = r_done;
  assign gt    = r_gt;
  assign eq    = r_eq;
  assign lt    = r_lt;

endmodule
